// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM7 instruction fetch stage.
package arm_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES       = 32'd4;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/arm_fetch_stage_if.sv
// Instruction-memory request/response bus plus the fetch-to-decode handshake.
interface arm_fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus8;
  logic        id_ready;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus8,
    input  imem_gnt, imem_rvalid, imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus8,
    output imem_gnt, imem_rvalid, imem_rdata, id_ready
  );

endinterface

// File: rtl/arm_fetch_fifo.sv
// Small instruction buffer holding {pc, instr} pairs between memory and decode.
module arm_fetch_fifo
  import arm_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  fetch_entry_t             wdata_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output fetch_entry_t             head_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PW+1)'(push_i) - (PW+1)'(do_pop);
    end
  end

  // Payload storage carries no reset; the top masks the head while empty.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/arm_fetch_stage.sv
// ARM7 fetch stage: PC sequencing, credit-limited memory requests, redirect flush.
module arm_fetch_stage
  import arm_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  arm_fetch_stage_if.master  bus,
  input  logic               pc_write,
  input  logic [31:0]        pc_update,
  output logic               fetch_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [OW-1:0] outst_q, outst_d;
  logic          fetch_err_q, fetch_err_d;

  logic          req, grant, resp_ok, push, pop, credit_ok;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head, fifo_wdata;
  logic          fifo_empty;

  // Every granted request must already own a FIFO slot for its response.
  assign credit_ok = (32'(outst_q) < 32'(MAX_OUTSTANDING)) &&
                     ((32'(outst_q) + 32'(fifo_count)) < 32'(FIFO_DEPTH));
  assign resp_ok   = bus.imem_rvalid && (outst_q != '0);
  assign pop       = bus.if_valid && bus.id_ready;
  assign fifo_wdata = '{pc: resp_pc_q, instr: bus.imem_rdata};

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    resp_pc_d   = resp_pc_q;
    req         = 1'b0;
    push        = 1'b0;
    fetch_err_d = fetch_err_q | (bus.imem_rvalid && (outst_q == '0));

    case (state_q)
      BOOT:    state_d = RUN;
      RUN: begin
        req  = !pc_write && credit_ok;
        push = resp_ok && !pc_write;
      end
      default: ;
    endcase

    grant   = req && bus.imem_gnt;
    outst_d = outst_q + OW'(grant) - OW'(resp_ok);

    if (grant) fetch_pc_d = fetch_pc_q + WORD_BYTES;
    if (push)  resp_pc_d  = resp_pc_q + WORD_BYTES;
    if (state_q == FLUSH && outst_d == '0) state_d = RUN;

    // Redirect overrides everything; stale responses are drained in FLUSH.
    if (pc_write) begin
      fetch_pc_d = word_align(pc_update);
      resp_pc_d  = word_align(pc_update);
      state_d    = (outst_d != '0) ? FLUSH : RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      fetch_pc_q  <= RESET_PC;
      resp_pc_q   <= RESET_PC;
      outst_q     <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      resp_pc_q   <= resp_pc_d;
      outst_q     <= outst_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  arm_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (pc_write),
    .wdata_i (fifo_wdata),
    .count_o (fifo_count),
    .head_o  (fifo_head),
    .empty_o (fifo_empty)
  );

  assign bus.imem_req    = req;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.if_valid    = !fifo_empty;
  assign bus.if_instr    = fifo_empty ? 32'h0 : fifo_head.instr;
  assign bus.if_pc       = fifo_empty ? RESET_PC : fifo_head.pc;
  assign bus.if_pc_plus8 = bus.if_pc + 32'd8;
  assign fetch_err       = fetch_err_q;

endmodule
